// File: rtl/dot_pkg.sv
// Shared types and helpers for the dot-product arbiter slice.
package dot_pkg;

  localparam int FP_W  = 32;
  localparam int E_W   = 8;
  localparam int R_MAX = 8;

  function automatic int UPPERLOG2(input int x);
    int w;
    w = 1;
    for (int k = 30; k >= 1; k--) begin
      if ((1 << k) >= x) w = k;
    end
    return w;
  endfunction

  // Bits needed to hold every value in 0..max_val.
  function automatic int RANGE(input int max_val);
    return UPPERLOG2(max_val + 1);
  endfunction

  // Tags are sized for the largest legal requester count so the type is shared.
  localparam int TAG_W = UPPERLOG2(R_MAX);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } shadow_t;

  typedef enum logic [1:0] {
    ARB,
    BURST,
    DRAIN
  } state_t;

endpackage

// File: rtl/dot_arbiter_if.sv
// Requester, datapath and response signals shared by the arbiter and its environment.
interface dot_arbiter_if
  import dot_pkg::*;
#(
  parameter int R = 4,
  parameter int N = 8
);
  localparam int D_W = FP_W * N;

  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_last;
  logic [R*D_W-1:0] req_data;
  logic [R-1:0]     req_ready;
  logic             dp_valid;
  logic [D_W-1:0]   dp_data;
  logic [FP_W-1:0]  dp_result;
  logic [R-1:0]     rsp_valid;
  logic [FP_W-1:0]  rsp_data;

  modport master (
    output req_valid, req_last, req_data, dp_result,
    input  req_ready, dp_valid, dp_data, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_last, req_data, dp_result,
    output req_ready, dp_valid, dp_data, rsp_valid, rsp_data
  );
endinterface

// File: rtl/dot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick
  import dot_pkg::*;
#(
  parameter int R = 4
) (
  input  logic [R-1:0]     req,
  input  logic [TAG_W-1:0] ptr,
  output logic [R-1:0]     grant,
  output logic [TAG_W-1:0] index
);

  int j;

  // Walk from the farthest candidate back toward ptr so the nearest one wins.
  always_comb begin
    grant = '0;
    index = '0;
    j     = 0;
    for (int k = R - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % R;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        index    = TAG_W'(j);
      end
    end
  end

endmodule

// File: rtl/dot_arbiter.sv
// Shares one fixed-latency dot-product datapath among R requesters with
// burst-locked round-robin, per-requester credits and tagged result return.
//
//   state | meaning
//   ARB   | pick next requester round-robin from rr_ptr
//   BURST | locked to owner until its req_last beat is accepted
//   DRAIN | flush requested; no acceptance, wait for pipeline to empty
module dot_arbiter
  import dot_pkg::*;
#(
  parameter int R       = 4,
  parameter int N       = 8,
  parameter int LAT     = 6,
  parameter int MAX_OUT = 8
) (
  input  logic          clock,
  input  logic          reset,
  dot_arbiter_if.slave  bus,
  input  logic          flush,
  output logic          flush_done,
  output logic          idle
);

  localparam int                 D_W      = FP_W * N;
  localparam int                 CNT_W    = RANGE(MAX_OUT);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [TAG_W-1:0]   LAST_IDX = TAG_W'(R - 1);

  state_t           state;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] owner;
  logic [CNT_W-1:0] out_cnt [R];
  shadow_t          shadow [LAT+1];

  logic [R-1:0]     credit_ok;
  logic [R-1:0]     pick_grant;
  logic [TAG_W-1:0] pick_idx;
  logic [R-1:0]     ready;
  logic [R-1:0]     acc_mask;
  logic [TAG_W-1:0] acc_idx;
  logic [TAG_W-1:0] next_ptr;
  logic [D_W-1:0]   acc_data;
  logic             accept;
  logic             acc_last;
  logic [R-1:0]     rsp_hit;
  logic             shadow_busy;
  logic             cnt_zero;

  // A response leaving this cycle frees its credit immediately.
  always_comb begin
    for (int i = 0; i < R; i++) begin
      credit_ok[i] = (out_cnt[i] < CNT_MAX) || bus.rsp_valid[i];
    end
  end

  rr_pick #(.R(R)) u_pick (
    .req   (bus.req_valid & credit_ok),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_idx)
  );

  always_comb begin
    ready   = '0;
    acc_idx = pick_idx;
    case (state)
      ARB: begin
        if (!flush) ready = pick_grant;
      end
      BURST: begin
        acc_idx = owner;
        for (int i = 0; i < R; i++) begin
          if (owner == TAG_W'(i)) ready[i] = credit_ok[i];
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready = ready;
  assign acc_mask      = ready & bus.req_valid;
  assign accept        = |acc_mask;
  assign acc_last      = |(acc_mask & bus.req_last);
  assign next_ptr      = (acc_idx == LAST_IDX) ? '0 : acc_idx + TAG_W'(1);

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < R; i++) begin
      if (acc_mask[i]) acc_data = bus.req_data[i*D_W +: D_W];
    end
  end

  always_comb begin
    shadow_busy = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      if (shadow[k].valid) shadow_busy = 1'b1;
    end
    cnt_zero = 1'b1;
    for (int i = 0; i < R; i++) begin
      if (out_cnt[i] != '0) cnt_zero = 1'b0;
    end
    for (int i = 0; i < R; i++) begin
      rsp_hit[i] = shadow[LAT].valid && (shadow[LAT].tag == TAG_W'(i));
    end
  end

  assign flush_done = (state == DRAIN) && !shadow_busy;
  assign idle       = (state == ARB) && cnt_zero && !(|bus.req_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ARB;
      rr_ptr        <= '0;
      owner         <= '0;
      bus.dp_valid  <= 1'b0;
      bus.dp_data   <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      for (int i = 0; i < R; i++) out_cnt[i] <= '0;
      for (int k = 0; k <= LAT; k++) shadow[k] <= '0;
    end else begin
      bus.dp_valid <= accept;
      if (accept) bus.dp_data <= acc_data;

      // Stage 0 is aligned with dp_valid; stage LAT with the matching dp_result.
      shadow[0] <= shadow_t'{valid: accept, tag: acc_idx};
      for (int k = 1; k <= LAT; k++) shadow[k] <= shadow[k-1];

      bus.rsp_valid <= rsp_hit;
      if (shadow[LAT].valid) bus.rsp_data <= bus.dp_result;

      for (int i = 0; i < R; i++) begin
        if (acc_mask[i] && !bus.rsp_valid[i]) out_cnt[i] <= out_cnt[i] + CNT_W'(1);
        else if (!acc_mask[i] && bus.rsp_valid[i]) out_cnt[i] <= out_cnt[i] - CNT_W'(1);
      end

      case (state)
        ARB: begin
          if (flush) begin
            state <= DRAIN;
          end else if (accept) begin
            if (acc_last) begin
              rr_ptr <= next_ptr;
            end else begin
              state <= BURST;
              owner <= acc_idx;
            end
          end
        end
        BURST: begin
          if (accept && acc_last) begin
            rr_ptr <= next_ptr;
            state  <= flush ? DRAIN : ARB;
          end
        end
        DRAIN: begin
          if (!flush) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_arbiter.sv
// Scoreboard bench for dot_arbiter: randomized and directed traffic against a behavioural model.
module tb_dot_arbiter;

  localparam int R       = 4;
  localparam int N       = 8;
  localparam int LAT     = 6;
  localparam int MAX_OUT = 2;
  localparam int D_W     = 32 * N;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic flush_done;
  logic idle;

  dot_arbiter_if #(.R(R), .N(N)) bus ();

  dot_arbiter #(.R(R), .N(N), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .flush      (flush),
    .flush_done (flush_done),
    .idle       (idle)
  );

  always #5 clock = ~clock;

  int     checks   = 0;
  int     failures = 0;
  longint cyc_n    = 0;

  always @(posedge clock) cyc_n <= cyc_n + 1;

  typedef struct {
    int          owner;
    logic [31:0] val;
    longint      due;
  } rsp_t;

  typedef struct {
    logic [D_W-1:0] data;
    longint         due;
  } dp_t;

  rsp_t           rsp_q[$];
  dp_t            dp_q[$];
  int             m_mode  = 0;  // 0 arbitrating, 1 locked to m_owner, 2 draining
  int             m_owner = 0;
  int             m_ptr   = 0;
  logic [D_W-1:0] m_last_dp = '0;
  bit             armed = 0;

  // Stand-in datapath: any fixed function of the beat, returned LAT cycles later.
  function automatic logic [31:0] dp_fn(input logic [D_W-1:0] d);
    logic [31:0] r;
    r = 32'h1234_5678;
    for (int k = 0; k < N; k++) r = {r[30:0], r[31]} ^ d[k*32 +: 32];
    return r;
  endfunction

  task automatic chk(input string name, input logic [D_W-1:0] act, input logic [D_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_n, act, exp);
    end
  endtask

  function automatic int pending(input int i, input longint c, input bit incl);
    int n;
    n = 0;
    foreach (rsp_q[k]) begin
      if ((i < 0 || rsp_q[k].owner == i) && (rsp_q[k].due > c || (incl && rsp_q[k].due == c))) n++;
    end
    return n;
  endfunction

  logic           hv [LAT+1];
  logic [D_W-1:0] hd [LAT+1];

  initial begin
    for (int k = 0; k <= LAT; k++) begin
      hv[k] = 1'b0;
      hd[k] = '0;
    end
    bus.dp_result = '0;
    forever begin
      @(negedge clock);
      for (int k = LAT; k > 0; k--) begin
        hv[k] = hv[k-1];
        hd[k] = hd[k-1];
      end
      hv[0] = bus.dp_valid;
      hd[0] = bus.dp_data;
      bus.dp_result = (hv[LAT] === 1'b1) ? dp_fn(hd[LAT]) : $urandom();
    end
  end

  task automatic monitor_step();
    longint         c;
    logic [R-1:0]   v;
    logic [R-1:0]   exp_rdy;
    logic [R-1:0]   acc;
    logic [R-1:0]   oh;
    int             pick;
    rsp_t           e;
    dp_t            d;
    c = cyc_n;
    if (reset) begin
      rsp_q.delete();
      dp_q.delete();
      m_mode    = 0;
      m_ptr     = 0;
      m_owner   = 0;
      m_last_dp = '0;
      armed     = 1;
      return;
    end
    if (!armed) return;
    v       = bus.req_valid;
    exp_rdy = '0;
    pick    = -1;
    if (m_mode == 0 && !flush) begin
      for (int k = 0; k < R; k++) begin
        int j;
        j = (m_ptr + k) % R;
        if (pick < 0 && v[j] && pending(j, c, 0) < MAX_OUT) pick = j;
      end
      if (pick >= 0) exp_rdy[pick] = 1'b1;
    end else if (m_mode == 1) begin
      if (pending(m_owner, c, 0) < MAX_OUT) exp_rdy[m_owner] = 1'b1;
    end
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("flush_done", flush_done, (m_mode == 2) && (pending(-1, c, 0) == 0));
    chk("idle", idle, (m_mode == 0) && (pending(-1, c, 1) == 0) && (v == '0));

    if (bus.dp_valid) begin
      if (dp_q.size() == 0) begin
        chk("dp_unexpected", bus.dp_valid, 1'b0);
      end else begin
        d = dp_q.pop_front();
        chk("dp_data", bus.dp_data, d.data);
        chk("dp_time", c, d.due);
        m_last_dp = d.data;
      end
    end else begin
      chk("dp_hold", bus.dp_data, m_last_dp);
      if (dp_q.size() > 0 && dp_q[0].due <= c) begin
        d = dp_q.pop_front();
        chk("dp_missing", bus.dp_valid, 1'b1);
      end
    end

    if (bus.rsp_valid != '0) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", bus.rsp_valid, '0);
      end else begin
        e = rsp_q.pop_front();
        oh = '0;
        oh[e.owner] = 1'b1;
        chk("rsp_owner", bus.rsp_valid, oh);
        chk("rsp_data", bus.rsp_data, e.val);
        chk("rsp_time", c, e.due);
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].due <= c) begin
      e = rsp_q.pop_front();
      oh = '0;
      oh[e.owner] = 1'b1;
      chk("rsp_missing", bus.rsp_valid, oh);
    end

    acc = v & bus.req_ready;
    for (int i = 0; i < R; i++) begin
      if (acc[i]) begin
        dp_q.push_back('{data: bus.req_data[i*D_W +: D_W], due: c + 1});
        rsp_q.push_back('{owner: i, val: dp_fn(bus.req_data[i*D_W +: D_W]), due: c + LAT + 2});
      end
    end

    case (m_mode)
      0: begin
        if (flush) m_mode = 2;
        else if (pick >= 0) begin
          if (bus.req_last[pick]) m_ptr = (pick + 1) % R;
          else begin
            m_mode  = 1;
            m_owner = pick;
          end
        end
      end
      1: begin
        if (exp_rdy[m_owner] && v[m_owner] && bus.req_last[m_owner]) begin
          m_ptr  = (m_owner + 1) % R;
          m_mode = flush ? 2 : 0;
        end
      end
      default: begin
        if (!flush) m_mode = 0;
      end
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clock);
      monitor_step();
    end
  end

  task automatic cyc(input logic [R-1:0] v, input logic [R-1:0] l, input logic f,
                     input logic r, output logic [R-1:0] acc);
    bus.req_valid = v;
    bus.req_last  = l;
    flush         = f;
    reset         = r;
    for (int i = 0; i < R * N; i++) bus.req_data[i*32 +: 32] = $urandom();
    @(negedge clock);
    acc = v & bus.req_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_n(input int n, input logic f);
    logic [R-1:0] a;
    repeat (n) cyc('0, '0, f, 1'b0, a);
  endtask

  // Sends an nb-beat burst from requester i; others present single-beat traffic meanwhile.
  task automatic send(input int i, input int nb, input logic [R-1:0] others,
                      input int flush_from, input bit gap);
    logic [R-1:0] a;
    logic [R-1:0] me;
    int           tries;
    me = '0;
    me[i] = 1'b1;
    for (int b = 0; b < nb; b++) begin
      if (gap && b == 1) cyc(others, others, (b >= flush_from), 1'b0, a);
      tries = 0;
      a = '0;
      while (!a[i] && tries < 40) begin
        cyc(me | others, ((b == nb - 1) ? me : '0) | others, (b >= flush_from), 1'b0, a);
        tries++;
      end
      if (!a[i]) chk("send_timeout", a[i], 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [R-1:0] a;
    logic         fl;
    logic         rs;
    logic [R-1:0] rv;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    repeat (3) cyc('0, '0, 1'b0, 1'b1, a);
    idle_n(3, 1'b0);

    cyc(4'b0100, 4'b0100, 1'b0, 1'b0, a);
    idle_n(12, 1'b0);

    repeat (8) cyc(4'b1111, 4'b1111, 1'b0, 1'b0, a);
    idle_n(12, 1'b0);

    send(1, 3, 4'b0001, 99, 1'b1);
    repeat (2) cyc(4'b0001, 4'b0001, 1'b0, 1'b0, a);
    idle_n(12, 1'b0);

    repeat (12) cyc(4'b1000, 4'b1000, 1'b0, 1'b0, a);
    idle_n(12, 1'b0);

    send(0, 4, 4'b0000, 1, 1'b0);
    repeat (12) cyc(4'b1111, 4'b1111, 1'b1, 1'b0, a);
    idle_n(4, 1'b0);
    idle_n(10, 1'b0);

    cyc(4'b0100, 4'b0100, 1'b0, 1'b0, a);
    cyc(4'b0010, 4'b0010, 1'b0, 1'b0, a);
    idle_n(2, 1'b0);
    cyc('0, '0, 1'b0, 1'b1, a);
    idle_n(12, 1'b0);

    fl = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rs = ($urandom_range(0, 299) == 0);
      if (fl) fl = ($urandom_range(0, 5) != 0);
      else    fl = ($urandom_range(0, 39) == 0);
      rv = rs ? '0 : R'($urandom());
      cyc(rv, R'($urandom()), fl, rs, a);
    end
    idle_n(15, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_arbiter.md
Name: dot_arbiter

Overview:
- Shares one fixed-latency dot-product datapath (N FP32 lanes, align/reduce/leading-one stages, no stall input) among R requesters.
- Round-robin arbitration on burst boundaries, with burst lock until req_last.
- Tags each issued beat through a LAT-deep shadow pipeline and steers each result back to its owner.
- Provides flush/drain so software can quiesce the unit before reconfiguration.

Parameters:
- R, 4: number of requesters (2..8).
- N, 8: FP32 lanes per beat; beat width D_W = 32*N.
- LAT, 6: datapath latency in cycles, from dp_valid/dp_data to dp_result (>=1).
- MAX_OUT, 8: maximum in-flight beats per requester (>=1, <=LAT+2).

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  R  per-requester beat valid.
- req_last  in  R  final beat of the requester's burst.
- req_data  in  R*D_W  per-requester beat; requester i occupies bits [i*D_W +: D_W].
- req_ready  out  R  beat accepted when req_valid[i]&req_ready[i].
- dp_valid  out  1  registered issue strobe to the datapath.
- dp_data  out  D_W  registered beat to the datapath.
- dp_result  in  32  datapath output, meaningful LAT cycles after dp_valid.
- rsp_valid  out  R  one-hot result strobe; no backpressure.
- rsp_data  out  32  registered result, shared by all requesters.
- flush  in  1  level request to stop accepting and drain.
- flush_done  out  1  high while flushing and the pipeline is empty.
- idle  out  1  high when ARB state, no beats in flight, and no req_valid.

Behaviour:
- Reset values: all req_ready, dp_valid, rsp_valid, flush_done = 0; dp_data and rsp_data = 0; idle = 1 (first cycle after reset); state = ARB; rr_ptr = 0; all outstanding counters = 0; shadow pipeline cleared.
- State ARB:
  - Grants the first i with req_valid[i] && out_cnt[i]<MAX_OUT, searching from rr_ptr upward with wrap.
  - req_ready goes high for that i only, in the same cycle. This is a combinational path from req_valid to req_ready; requesters must not make req_valid depend on req_ready.
  - On acceptance with req_last=1: stay in ARB and set rr_ptr = i+1 mod R.
  - On acceptance with req_last=0: go to BURST(owner=i).
- State BURST:
  - Only the owner may get req_ready, asserted when out_cnt[owner]<MAX_OUT.
  - Other requesters are held off even if the owner idles (req_valid=0).
  - Accepting a beat with req_last=1 returns to ARB with rr_ptr = owner+1.
- State DRAIN:
  - Entered from ARB when flush=1, or from BURST when flush=1 and the owner's last beat is accepted.
  - All req_ready = 0.
  - flush_done = 1 once the shadow pipeline is empty.
  - Returns to ARB when flush deasserts.
  - flush arriving mid-burst does not break the burst lock.
- Issue: an accepted beat in cycle t drives dp_valid=1 and dp_data=beat in cycle t+1. dp_valid is 0 and dp_data holds its value in all other cycles.
- Shadow pipeline: LAT+1 stages of {valid, owner tag}, aligned so that dp_result sampled at t+1+LAT is registered to rsp_data at t+2+LAT. rsp_valid[owner] is 1 for exactly one cycle. Total request-to-response latency is LAT+2 cycles.
- out_cnt[i]:
  - Increments on acceptance from i and decrements on rsp_valid[i].
  - Simultaneous increment and decrement leaves it unchanged.
  - It never exceeds MAX_OUT, because ready is suppressed at the limit.
- Order: responses are returned in issue order; at most one response per cycle.
- Reset mid-operation:
  - Shadow valids are cleared, so results of in-flight beats are discarded and never strobed.
  - Counters are zeroed and state returns to ARB.
  - dp_result garbage after reset is ignored.

Decomposition:
- Shared package dot_pkg holds:
  - constants FP_W=32 and E_W=8;
  - functions UPPERLOG2 and RANGE;
  - the typedef for the shadow stage {valid, tag[UPPERLOG2(R)-1:0]};
  - the state enum {ARB, BURST, DRAIN}.
- Natural sub-module: rr_pick, a combinational round-robin priority picker (inputs: request mask, pointer; output: one-hot grant, index).
- The shadow pipeline and counters stay in dot_arbiter.

Test Plan:
- Single beat: R=4, LAT=6. Requester 2 sends one beat with last=1 at cycle 10 -> dp_valid at 11; rsp_valid=4'b0100 at 18 with rsp_data = dp_result sampled at 17.
- Fairness: all 4 requesters hold valid with single-beat bursts for 8 cycles -> grants go 0,1,2,3,0,1,2,3; each rsp_valid bit fires twice, in that order.
- Burst lock: requester 1 sends a 3-beat burst while requester 0 is valid -> req_ready[0]=0 for the 3 beats, including a gap cycle where requester 1's valid is 0; requester 0 is granted on the cycle after requester 1's last beat.
- Credit limit: MAX_OUT=2, requester 3 streams -> req_ready[3] drops after 2 accepts; it reasserts in the cycle its first rsp_valid[3] fires (out_cnt=1).
- Flush mid-burst: flush=1 during requester 0's 4-beat burst -> the remaining beats are still accepted; then all ready=0; flush_done=1 exactly LAT+2 cycles after the last accept; ARB resumes when flush=0.
- Reset mid-flight: reset pulses 3 cycles after 2 beats are issued -> no rsp_valid ever fires for those beats; idle=1 after reset; out_cnt=0.
